// File: rtl/bank_array.sv
// Multi-bank 1W/1R word array with byte enables, post-reset zero-fill sweep and a
// two-cycle read pipeline. Define BANK_ARRAY_FWD_EN for write-first same-address reads.
module bank_array #(
    parameter  int unsigned DATA_W = 128,
    parameter  int unsigned DEPTH  = 128,
    parameter  int unsigned BANKS  = 4,
    localparam int unsigned BE_W   = DATA_W / 8,
    localparam int unsigned ROW_W  = $clog2(DEPTH),
    localparam int unsigned BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 0,
    localparam int unsigned ADDR_W = ROW_W + BSEL_W
) (
    input  logic              vsi_clk,
    input  logic              vsi_reset_n,
    output logic              vsi_ready,
    input  logic              vsi_wrEn,
    input  logic [ADDR_W-1:0] vsi_wrAddr,
    input  logic [DATA_W-1:0] vsi_wrData,
    input  logic [BE_W-1:0]   vsi_wrBe,
    input  logic              vsi_rdEn,
    input  logic [ADDR_W-1:0] vsi_rdAddr,
    output logic              vsi_rdValid,
    output logic [DATA_W-1:0] vsi_rdData
);

    localparam int unsigned BI_W = (BSEL_W > 0) ? BSEL_W : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ROW_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic             fill_c;

    logic             wr_fire_c, rd_fire_c;
    logic [BI_W-1:0]  wr_bank_c, rd_bank_c;
    logic [ROW_W-1:0] wr_row_c, rd_row_c;

    logic [DATA_W-1:0] mem_q [BANKS][DEPTH];
    logic [DATA_W-1:0] rd_word_c, s1_d_c;

    logic              s1_v_q, s2_v_q, rdv_q;
    logic [DATA_W-1:0] s1_data_q, s2_data_q, rdd_q;

    // Low-order interleave: bank from the LSBs, row from the rest
    if (BANKS > 1) begin : g_multi
        assign wr_bank_c = vsi_wrAddr[BSEL_W-1:0];
        assign wr_row_c  = vsi_wrAddr[ADDR_W-1:BSEL_W];
        assign rd_bank_c = vsi_rdAddr[BSEL_W-1:0];
        assign rd_row_c  = vsi_rdAddr[ADDR_W-1:BSEL_W];
    end else begin : g_single
        assign wr_bank_c = '0;
        assign wr_row_c  = vsi_wrAddr;
        assign rd_bank_c = '0;
        assign rd_row_c  = vsi_rdAddr;
    end

    assign wr_fire_c = vsi_wrEn & ready_q;
    assign rd_fire_c = vsi_rdEn & ready_q;

    // Sweep FSM: INIT zero-fills one row of every bank per cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_c  = 1'b0;
        case (state_q)
            ST_INIT: begin
                fill_c = 1'b1;
                cnt_d  = cnt_q + ROW_W'(1);
                if (cnt_q == ROW_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_q == ST_READY);
        end
    end

    // Storage: sweep writes zero rows, otherwise byte-masked user writes
    always_ff @(posedge vsi_clk) begin
        if (fill_c) begin
            for (int b = 0; b < BANKS; b++) begin
                mem_q[BI_W'(b)][cnt_q] <= '0;
            end
        end else if (wr_fire_c) begin
            for (int i = 0; i < BE_W; i++) begin
                if (vsi_wrBe[i]) begin
                    mem_q[wr_bank_c][wr_row_c][8*i +: 8] <= vsi_wrData[8*i +: 8];
                end
            end
        end
    end

    assign rd_word_c = mem_q[rd_bank_c][rd_row_c];

`ifdef BANK_ARRAY_FWD_EN
    // Write-first: merge enabled write bytes into a same-address read
    always_comb begin
        s1_d_c = rd_word_c;
        if (wr_fire_c && (vsi_wrAddr == vsi_rdAddr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (vsi_wrBe[i]) begin
                    s1_d_c[8*i +: 8] = vsi_wrData[8*i +: 8];
                end
            end
        end
    end
`else
    assign s1_d_c = rd_word_c;
`endif

    // Read pipeline: array word on the request edge, output two edges later
    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            rdv_q     <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
            rdd_q     <= '0;
        end else begin
            s1_v_q <= rd_fire_c;
            s2_v_q <= s1_v_q;
            rdv_q  <= s2_v_q;
            if (rd_fire_c) begin
                s1_data_q <= s1_d_c;
            end
            if (s1_v_q) begin
                s2_data_q <= s1_data_q;
            end
            if (s2_v_q) begin
                rdd_q <= s2_data_q;
            end
        end
    end

    assign vsi_ready   = ready_q;
    assign vsi_rdValid = rdv_q;
    assign vsi_rdData  = rdd_q;

endmodule

// File: tb/tb_bank_array.sv
// Directed bench for bank_array (default parameters); expectations follow
// BANK_ARRAY_FWD_EN when it is defined.
module tb_bank_array;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned BANKS  = 4;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned BE_W   = 16;
    localparam int unsigned WORDS  = DEPTH * BANKS;

`ifdef BANK_ARRAY_FWD_EN
    localparam logic [DATA_W-1:0] SAME_EXP = 128'h1234;
`else
    localparam logic [DATA_W-1:0] SAME_EXP = '0;
`endif

    logic              clk;
    logic              rst_n;
    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Expected read pipeline: slot 2 is what should appear this cycle
    logic              pv [3];
    logic [DATA_W-1:0] pd [3];
    string             pt [3];
    logic              up;

    logic [DATA_W-1:0] p5;

    bank_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BANKS(BANKS)) dut (
        .vsi_clk     (clk),
        .vsi_reset_n (rst_n),
        .vsi_ready   (ready),
        .vsi_wrEn    (wr_en),
        .vsi_wrAddr  (wr_addr),
        .vsi_wrData  (wr_data),
        .vsi_wrBe    (wr_be),
        .vsi_rdEn    (rd_en),
        .vsi_rdAddr  (rd_addr),
        .vsi_rdValid (rd_valid),
        .vsi_rdData  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
            pt[i] = "none";
        end
    endtask

    // One clock: push current request, advance, check valid/data, drop requests
    task automatic step(input string tag, input logic [DATA_W-1:0] rexp);
        pv[2] = pv[1]; pd[2] = pd[1]; pt[2] = pt[1];
        pv[1] = pv[0]; pd[1] = pd[0]; pt[1] = pt[0];
        pv[0] = rd_en && up; pd[0] = rexp; pt[0] = tag;
        @(negedge clk);
        chk({pt[2], "_valid"}, DATA_W'(rd_valid), DATA_W'(pv[2]));
        if (pv[2]) chk({pt[2], "_data"}, rd_data, pd[2]);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step("wr", '0);
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        rd_en = 1'b1; rd_addr = a;
        step(tag, exp);
    endtask

    task automatic drain();
        repeat (3) step("idle", '0);
    endtask

    // Sweep after reset release: ready low for DEPTH edges, high after one more
    task automatic sweep(input bit inject);
        for (int i = 1; i <= int'(DEPTH); i++) begin
            if (inject && i == 10) begin
                wr_en = 1'b1; wr_addr = 9'd3; wr_data = 128'hDEAD; wr_be = '1;
                rd_en = 1'b1; rd_addr = 9'd3;
            end
            step("init_rd", 128'hDEAD);
            chk("ready_init", DATA_W'(ready), '0);
        end
        step("idle", '0);
        chk("ready_up", DATA_W'(ready), DATA_W'(1));
        up = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        up = 1'b0;
        clear_pipe();

        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", DATA_W'(ready), '0);
        chk("rst_valid", DATA_W'(rd_valid), '0);
        chk("rst_data", rd_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First sweep, with a write/read of addr 3 attempted mid-sweep
        sweep(1'b1);

        // Every word reads zero, back-to-back
        for (int k = 0; k < int'(WORDS); k++) begin
            rd("zero", ADDR_W'(k), '0);
        end
        drain();

        // Byte enables
        wr(9'd5, {16{8'hA5}}, '1);
        wr(9'd5, '1, 16'h0001);
        p5 = {{15{8'hA5}}, 8'hFF};
        rd("be_merge", 9'd5, p5);
        wr(9'd5, '0, '0);
        rd("be_zero", 9'd5, p5);
        drain();

        // Same-cycle same-address write and read
        wr_en = 1'b1; wr_addr = 9'd9; wr_data = 128'h1234; wr_be = '1;
        rd_en = 1'b1; rd_addr = 9'd9;
        step("same_addr", SAME_EXP);
        rd("after_same", 9'd9, 128'h1234);
        drain();

        // Same bank, different rows, same cycle
        wr_en = 1'b1; wr_addr = 9'd13; wr_data = 128'h77; wr_be = '1;
        rd_en = 1'b1; rd_addr = 9'd5;
        step("same_bank", p5);
        rd("bank_wr", 9'd13, 128'h77);
        drain();

        // Streaming writes then streaming reads
        for (int k = 0; k < int'(WORDS); k++) begin
            wr(ADDR_W'(k), DATA_W'(k), '1);
        end
        for (int k = 0; k < int'(WORDS); k++) begin
            rd("stream", ADDR_W'(k), DATA_W'(k));
        end
        drain();

        // Reset with two reads in flight
        rd("flight1", 9'd1, DATA_W'(1));
        rd("flight2", 9'd2, DATA_W'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", DATA_W'(rd_valid), '0);
        chk("mid_rst_data", rd_data, '0);
        chk("mid_rst_ready", DATA_W'(ready), '0);
        clear_pipe();
        up = 1'b0;
        @(negedge clk);
        chk("rst_hold_valid", DATA_W'(rd_valid), '0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(1'b0);

        rd("post_sweep", 9'd1, '0);
        rd("post_sweep3", 9'd3, '0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
